// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Package only: no logic, no latency, no flow control.
package adder_pkg;
    localparam int   NIBBLE_W = 4;
    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle between an operand source and the serial adder.
// Wires only; valid/ready on both the request and the result side.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, fully combinational.
// Zero latency; no flow control.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:1] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is flattened to two levels so the slice has no ripple.
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum = w_p ^ {w_c[3], w_c[2], w_c[1], cin};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced over one 4-bit CLA slice, one nibble per cycle.
// Latency WIDTH/4 cycles accept-to-result; holds the result in DONE until out_ready.
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    nibble_serial_adder_ctrl_if.slave  bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t              r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic                r_out_valid;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic                w_slice_cout;
    logic                w_idle;
    logic                w_last;

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // The unused fourth state code behaves exactly like IDLE.
    assign w_idle = !((r_state == ST_RUN) || (r_state == ST_DONE));
    assign w_last = (r_idx == IDX_W'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (r_idx == IDX_W'(k))
                            r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_slice_sum;
                    end
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_cout      <= w_slice_cout;
                        // r_b is already inverted for subtract, so one rule covers both ops.
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_slice_sum[NIBBLE_W-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        r_carry <= (bus.op == OP_SUB) ? 1'b1 : bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.busy      = !w_idle;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead slice over WIDTH/4 cycles. The inter-nibble carry is registered between cycles. Operands arrive and results leave over valid/ready handshakes. It sits between the operand source (register file or ALU front end) and the result consumer, trading latency for a single small adder.

## Interface
- WIDTH, 16: operand width in bits; multiple of 4, ≥ 8
- NIB, WIDTH/4: derived nibble count; not overridable
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  controller can accept request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add; ignored for subtract
- op  in  1  0 = A+B+cin, 1 = A−B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB nibble (subtract: 1 = no borrow)
- overflow  out  1  two's-complement signed overflow
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE (2-bit encoding; the spare code decodes to IDLE).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a → A_r and (op ? ~b : b) → B_r.
  - Load carry_r ← (op ? 1 : cin), set idx ← 0, clear the sum register, go to RUN.
- RUN:
  - Each cycle the slice sees A_r[4·idx+3:4·idx], B_r[same], carry_r.
  - At the edge: write slice Sum into sum[4·idx+3:4·idx], carry_r ← slice Cout, idx ← idx+1.
  - When idx = NIB−1: set cout ← slice Cout, compute overflow, go to DONE.
- overflow = (A_r[MSB] == B_r[MSB]) & (sum[MSB] != A_r[MSB]), using the inverted B_r for subtract.
- DONE:
  - out_valid = 1; sum, cout and overflow are stable.
  - On out_valid & out_ready: go to IDLE.
  - sum, cout and overflow hold their values until the next accept.
- in_ready = (state == IDLE). in_valid is ignored in RUN and DONE; there is no same-cycle accept in DONE.
- Reset, including mid-RUN: state IDLE, idx 0, carry_r 0, sum 0, cout 0, overflow 0, out_valid 0, busy 0. in_ready reads 1 throughout. Any in-flight operation is discarded.
- idx is $clog2(NIB) bits wide and never wraps past NIB−1.

## Timing
- Accept edge E0 → RUN. Nibble k is written at edge E(k+1).
- Edge E(NIB) writes the last nibble and enters DONE. out_valid is first high in the cycle after E(NIB).
- Latency is NIB cycles from accept to out_valid (4 for WIDTH=16).
- With out_ready held high: out_valid lasts 1 cycle, then 1 cycle in IDLE. Minimum initiation interval is NIB+2 cycles.
- All outputs are registered except in_ready and busy, which decode directly from the state register.
- The slice path is purely combinational: registered operands → slice → sum/carry registers, all within one cycle.

## Structure
- Shared package adder_pkg:
  - state enum ST_IDLE/ST_RUN/ST_DONE
  - NIBBLE_W = 4
  - OP_ADD = 1'b0, OP_SUB = 1'b1
- Sub-module cla4_slice: 4-bit carry-lookahead slice.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Generate/propagate per bit. Full lookahead: cout = G3 | P3G2 | P3P2G1 | P3P2P1G0 | P3P2P1P0·cin.
  - Instantiated once.
- The controller holds the FSM, operand registers, idx, carry_r and result registers.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, op=0 → sum=0x5555, cout=0, overflow=0. out_valid rises exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, op=0 → sum=0x0000, cout=1, overflow=0 (carry ripples through all nibbles). Also a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- op=1, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, overflow=1. Also op=1, a=0x0003, b=0x0005, cin=1 → sum=0xFFFE, cout=0 (cin ignored).
- Hold out_ready=0 for 5 cycles in DONE → out_valid, sum, cout and overflow stable; in_ready=0. A new in_valid with different operands stays unaccepted until one cycle after the out handshake.
- Drive rst_n low for 1 cycle at idx=2 of a RUN → all outputs 0, in_ready=1, busy=0. The next request a=0x0F0F, b=0x00F1, cin=0, op=0 → sum=0x1000 with no residue from the aborted operation.
- Back-to-back requests with in_valid and out_ready held high → accepts spaced exactly NIB+2 = 6 cycles apart, and each result matches the reference model (a + (op ? ~b : b) + carry-in) mod 2^16.
